// File: rtl/ctl_score_pkg.sv
// Shared types and constants for the serial BCD score counter.
package ctl_score_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    typedef enum logic {
        IDLE,
        ADD
    } state_t;

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder with carry in/out.
module bcd_digit_add
    import ctl_score_pkg::*;
(
    input  bcd_t a,
    input  bcd_t b,
    input  logic cin,
    output bcd_t sum,
    output logic cout
);

    logic [4:0] raw;

    always_comb begin
        raw = 5'(a) + 5'(b) + 5'(cin);
        if (raw > 5'(BCD_MAX)) begin
            sum  = 4'(raw - 5'd10);
            cout = 1'b1;
        end else begin
            sum  = raw[3:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/ctl_score_bcd.sv
// Serial packed-BCD score counter: one digit per clock, atomic commit, queued hits.
// Optional high-score register enabled by defining CTL_SCORE_HISCORE_EN.
module ctl_score_bcd
    import ctl_score_pkg::*;
#(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned HIT_POINTS = 1,
    parameter int unsigned SATURATE   = 1,
    parameter int unsigned PENDING_W  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                reset_score,
    input  logic                hit,
    output logic [DIGITS*4-1:0] score,
    output logic                busy,
    output logic                overflow,
    output logic [DIGITS*4-1:0] hiscore,
    output logic                new_high
);

    localparam int unsigned W     = DIGITS * 4;
    localparam int unsigned IDX_W = $clog2(DIGITS);
    localparam bcd_t                 ADDEND   = bcd_t'(HIT_POINTS);
    localparam logic [W-1:0]         NINES    = {DIGITS{BCD_MAX}};
    localparam logic [PENDING_W-1:0] PEND_MAX = '1;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 carry_q, carry_d;
    bcd_t [DIGITS-1:0]    work_q, work_d;
    logic [W-1:0]         score_q, score_d;
    logic [PENDING_W-1:0] pending_q, pending_d, pend_eff;
    logic                 overflow_q, overflow_d;
    logic                 hit_last_q, hit_edge, last_digit, commit;
    bcd_t                 dig_b, dig_sum;
    logic                 dig_cout;

    assign hit_edge   = hit & ~hit_last_q;
    assign last_digit = (idx_q == IDX_W'(DIGITS - 1));
    assign commit     = (state_q == ADD) && last_digit && !reset_score;
    assign dig_b      = (idx_q == '0) ? ADDEND : '0;
    assign pend_eff   = !hit_edge                ? pending_q :
                        (pending_q == PEND_MAX)  ? pending_q : pending_q + 1'b1;

    bcd_digit_add u_digit (
        .a    (work_q[idx_q]),
        .b    (dig_b),
        .cin  (carry_q),
        .sum  (dig_sum),
        .cout (dig_cout)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        carry_d    = carry_q;
        work_d     = work_q;
        score_d    = score_q;
        pending_d  = pending_q;
        overflow_d = overflow_q;
        if (reset_score) begin
            state_d    = IDLE;
            score_d    = '0;
            overflow_d = 1'b0;
            pending_d  = '0;
        end else if (state_q == IDLE) begin
            if (hit_edge) begin
                state_d = ADD;
                work_d  = score_q;
                idx_d   = '0;
                carry_d = 1'b0;
            end
        end else begin
            work_d[idx_q] = dig_sum;
            carry_d       = dig_cout;
            idx_d         = idx_q + 1'b1;
            pending_d     = pend_eff;
            if (commit) begin
                score_d = work_d;
                if (dig_cout) begin
                    overflow_d = 1'b1;
                    if (SATURATE != 0) score_d = NINES;
                end
                // Chain straight into the next queued add from the value just committed.
                if (pend_eff != '0) begin
                    pending_d = pend_eff - 1'b1;
                    work_d    = score_d;
                    idx_d     = '0;
                    carry_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            work_q     <= '0;
            score_q    <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            hit_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            carry_q    <= carry_d;
            work_q     <= work_d;
            score_q    <= score_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            hit_last_q <= hit;
        end
    end

    assign score    = score_q;
    assign busy     = (state_q == ADD);
    assign overflow = overflow_q;

`ifdef CTL_SCORE_HISCORE_EN
    logic         commit_d_q;
    logic [W-1:0] hiscore_q;
    logic         new_high_q;

    // Packed BCD orders like its decimal value, so a plain unsigned compare suffices.
    always_ff @(posedge clk) begin
        if (rst) begin
            commit_d_q <= 1'b0;
            hiscore_q  <= '0;
            new_high_q <= 1'b0;
        end else begin
            commit_d_q <= commit;
            new_high_q <= 1'b0;
            if (commit_d_q && (score_q > hiscore_q)) begin
                hiscore_q  <= score_q;
                new_high_q <= 1'b1;
            end
        end
    end

    assign hiscore  = hiscore_q;
    assign new_high = new_high_q;
`else
    assign hiscore  = '0;
    assign new_high = 1'b0;
`endif

endmodule
